// File: rtl/uart_frame_sequencer.sv
// uart_frame_sequencer: snapshots NCH tagged channel payloads on frame_tick and streams
// them to a UART TX as SYNC, {tag,payload} words MSB byte first, then an XOR checksum.
module uart_frame_sequencer #(
    parameter int         NCH       = 7,
    parameter int         TAG_W     = 4,
    parameter int         FIRST_TAG = 1,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    localparam int        PAYLOAD_W = 16 - TAG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic [NCH*PAYLOAD_W-1:0] ch_data,
    input  logic [NCH-1:0]           ch_en,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun
);
    localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
    typedef enum logic [2:0] {IDLE, SYNC, HI, LO, CSUM} state_t;
    state_t                   state;
    logic [NCH*PAYLOAD_W-1:0] snap;
    logic [NCH-1:0]           en_q;
    logic [IW-1:0]            idx;
    logic [7:0]               csum;
    logic                     xfer;
    logic                     found;
    logic [IW-1:0]            nxt;
    logic [7:0]               hi_nxt;
    logic [7:0]               lo_cur;
    logic [7:0]               csum_nx;
    assign xfer    = tx_valid && tx_ready;
    assign csum_nx = state == LO ? csum ^ tx_data : csum;
    // From SYNC the search starts at channel 0, from LO strictly above the current channel.
    always_comb begin
        found  = 1'b0;
        nxt    = '0;
        hi_nxt = '0;
        lo_cur = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (en_q[i] && (state == SYNC || i > int'(idx))) begin
                found = 1'b1;
                nxt   = IW'(i);
            end
        for (int i = 0; i < NCH; i++) begin
            if (IW'(i) == nxt) hi_nxt = {TAG_W'(FIRST_TAG + i), snap[i*PAYLOAD_W+8 +: PAYLOAD_W-8]};
            if (IW'(i) == idx) lo_cur = snap[i*PAYLOAD_W +: 8];
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            snap       <= '0;
            en_q       <= '0;
            idx        <= '0;
            csum       <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            overrun    <= frame_tick && state != IDLE;
            case (state)
                IDLE: if (frame_tick) begin
                    snap     <= ch_data;
                    en_q     <= ch_en;
                    idx      <= '0;
                    csum     <= '0;
                    tx_data  <= SYNC_BYTE;
                    tx_valid <= 1'b1;
                    busy     <= 1'b1;
                    state    <= SYNC;
                end
                SYNC, LO: if (xfer) begin
                    csum <= csum_nx;
                    if (found) begin
                        idx     <= nxt;
                        tx_data <= hi_nxt;
                        state   <= HI;
                    end else begin
                        tx_data <= csum_nx;
                        state   <= CSUM;
                    end
                end
                HI: if (xfer) begin
                    csum    <= csum ^ tx_data;
                    tx_data <= lo_cur;
                    state   <= LO;
                end
                CSUM: if (xfer) begin
                    tx_valid   <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_sequencer.sv
// tb_uart_frame_sequencer: a 2-channel and a default 7-channel instance checked each cycle
// against a byte-queue model of the frame format, plus literal byte streams.
module tb_uart_frame_sequencer;
    localparam int PW = 12;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      tick = '0;
    logic [1:0]      rdy = '1;
    logic [23:0]     cd2 = '0;
    logic [1:0]      en2 = '0;
    logic [83:0]     cd7 = '0;
    logic [6:0]      en7 = '0;
    logic [1:0][7:0] tx_data;
    logic [1:0]      tx_valid, busy, frame_done, overrun;
    int              compared = 0;
    int              mismatched = 0;
    logic [7:0]      expq [2][$];
    logic [7:0]      got0 [$];
    logic [1:0]      exp_done = '0;
    logic [1:0]      exp_ov = '0;
    int              done_cnt [2];
    int              ov_cnt [2];
    bit              was;
    always #5 clk = ~clk;
    uart_frame_sequencer #(.NCH(2)) dut2 (
        .clk(clk), .rst(rst), .frame_tick(tick[0]), .ch_data(cd2), .ch_en(en2),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(rdy[0]),
        .busy(busy[0]), .frame_done(frame_done[0]), .overrun(overrun[0])
    );
    uart_frame_sequencer dut7 (
        .clk(clk), .rst(rst), .frame_tick(tick[1]), .ch_data(cd7), .ch_en(en7),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(rdy[1]),
        .busy(busy[1]), .frame_done(frame_done[1]), .overrun(overrun[1])
    );
    task automatic chk(string nm, int d, logic [7:0] act, logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
        end
    endtask
    // Expected frame as a byte list: SYNC, HI/LO per enabled channel, XOR of HI/LO bytes.
    task automatic build(int d, logic [83:0] data, logic [6:0] en, int n);
        int p, hi, lo, cs;
        cs = 0;
        expq[d].push_back(8'hA5);
        for (int i = 0; i < n; i++)
            if (en[i]) begin
                p  = int'((data >> (i * PW)) & 84'hFFF);
                hi = ((1 + i) << 4) | (p >> 8);
                lo = p & 255;
                cs = cs ^ hi ^ lo;
                expq[d].push_back(8'(hi));
                expq[d].push_back(8'(lo));
            end
        expq[d].push_back(8'(cs));
    endtask
    initial begin
        done_cnt = '{0, 0};
        ov_cnt   = '{0, 0};
    end
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                expq[d].delete();
                exp_done[d] = 1'b0;
                exp_ov[d]   = 1'b0;
                chk("reset_flags", d, 8'({tx_valid[d], busy[d], frame_done[d], overrun[d]}), 8'h00);
                chk("reset_data", d, tx_data[d], 8'h00);
            end else begin
                was = expq[d].size() > 0;
                chk("busy", d, 8'(busy[d]), 8'(was));
                chk("tx_valid", d, 8'(tx_valid[d]), 8'(was));
                chk("frame_done", d, 8'(frame_done[d]), 8'(exp_done[d]));
                chk("overrun", d, 8'(overrun[d]), 8'(exp_ov[d]));
                if (frame_done[d]) done_cnt[d]++;
                if (overrun[d]) ov_cnt[d]++;
                exp_done[d] = 1'b0;
                exp_ov[d]   = 1'b0;
                if (tx_valid[d] && was) begin
                    chk("tx_data", d, tx_data[d], expq[d][0]);
                    if (rdy[d]) begin
                        if (d == 0) got0.push_back(tx_data[d]);
                        void'(expq[d].pop_front());
                        if (expq[d].size() == 0) exp_done[d] = 1'b1;
                    end
                end
                if (tick[d]) begin
                    if (was) exp_ov[d] = 1'b1;
                    else if (d == 0) build(0, {60'b0, cd2}, {5'b0, en2}, 2);
                    else build(1, cd7, en7, 7);
                end
            end
        end
    end
    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic start2(logic [23:0] data, logic [1:0] en);
        cd2     = data;
        en2     = en;
        tick[0] = 1'b1;
        cyc(1);
        tick[0] = 1'b0;
    endtask
    task automatic wait_idle(int d);
        int n;
        n = 0;
        while (expq[d].size() > 0 && n < 400) begin
            cyc(1);
            n++;
        end
        chk("frame_timeout", d, 8'(n >= 400), 8'h00);
        cyc(2);
    endtask
    task automatic expect_stream(string nm, logic [63:0] v, int n);
        chk({nm, "_len"}, 0, 8'(got0.size()), 8'(n));
        for (int i = 0; i < n && i < got0.size(); i++)
            chk(nm, 0, got0[i], v[8*(n-1-i) +: 8]);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        int d0, o0, n;
        cyc(2);
        chk("lit_reset_valid", 0, 8'({tx_valid[0], busy[0], tx_valid[1], busy[1]}), 8'h00);
        rst = 1'b0;
        cyc(2);
        // basic two-channel frame
        got0.delete();
        d0 = done_cnt[0];
        start2(24'hABC123, 2'b11);
        wait_idle(0);
        expect_stream("t1_stream", 64'hA511232ABCA4, 6);
        chk("t1_done_pulses", 0, 8'(done_cnt[0] - d0), 8'd1);
        chk("t1_busy_low", 0, 8'(busy[0]), 8'h00);
        // stall while 8'h23 is presented
        got0.delete();
        start2(24'hABC123, 2'b11);
        cyc(2);
        rdy[0] = 1'b0;
        cyc(5);
        chk("t2_held_data", 0, tx_data[0], 8'h23);
        chk("t2_held_valid", 0, 8'(tx_valid[0]), 8'h01);
        rdy[0] = 1'b1;
        wait_idle(0);
        expect_stream("t2_stream", 64'hA511232ABCA4, 6);
        // partial and empty masks
        got0.delete();
        start2(24'hABC123, 2'b10);
        wait_idle(0);
        expect_stream("t3_mask10", 64'hA52ABC96, 4);
        got0.delete();
        d0 = done_cnt[0];
        start2(24'hABC123, 2'b00);
        wait_idle(0);
        expect_stream("t3_mask00", 64'hA500, 2);
        chk("t3_done_pulses", 0, 8'(done_cnt[0] - d0), 8'd1);
        // data change plus frame_tick during HI of ch0
        got0.delete();
        o0 = ov_cnt[0];
        start2(24'hABC123, 2'b11);
        cyc(1);
        cd2     = '0;
        tick[0] = 1'b1;
        cyc(1);
        tick[0] = 1'b0;
        wait_idle(0);
        expect_stream("t4_stream", 64'hA511232ABCA4, 6);
        chk("t4_overrun_pulses", 0, 8'(ov_cnt[0] - o0), 8'd1);
        cyc(3);
        chk("t4_no_restart", 0, 8'(busy[0]), 8'h00);
        // asynchronous reset during LO of ch1
        start2(24'hABC123, 2'b11);
        cyc(4);
        chk("t5_pre_lo1", 0, tx_data[0], 8'hBC);
        #1 rst = 1'b1;
        #1;
        chk("t5_async_valid", 0, 8'(tx_valid[0]), 8'h00);
        chk("t5_async_busy", 0, 8'(busy[0]), 8'h00);
        chk("t5_async_data", 0, tx_data[0], 8'h00);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        got0.delete();
        start2(24'hABC123, 2'b11);
        wait_idle(0);
        expect_stream("t5_stream", 64'hA511232ABCA4, 6);
        // seven channels, random data and handshake
        for (int f = 0; f < 8; f++) begin
            d0  = done_cnt[1];
            cd7 = {20'($urandom), $urandom, $urandom};
            en7 = f == 0 ? 7'h7F : f == 1 ? 7'h00 : 7'($urandom);
            tick[1] = 1'b1;
            cyc(1);
            tick[1] = 1'b0;
            n = 0;
            while (expq[1].size() > 0 && n < 600) begin
                rdy[1] = 1'($urandom_range(0, 1));
                cyc(1);
                n++;
            end
            rdy[1] = 1'b1;
            chk("t6_timeout", 1, 8'(n >= 600), 8'h00);
            cyc(3);
            chk("t6_done_pulses", 1, 8'(done_cnt[1] - d0), 8'd1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
